debounce_synchronizer: RTL and testbench

- Front-end conditioning stage placed directly upstream of posedge_detector / one_cycle_pulse_detector.
- Takes a raw, asynchronous, bouncy input (button, external strobe) and synchronizes it with a 2-flop synchronizer.
- Qualifies each level change by requiring it to hold for STABLE_CYCLES consecutive clocks.
- Drives a clean, glitch-free registered level that the edge/pulse detectors consume as their `a` input.

---
 rtl/debounce_synchronizer_if.sv | 30 +++
 rtl/debounce_synchronizer.sv | 131 +++++++++++++
 tb/tb_debounce_synchronizer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/debounce_synchronizer_if.sv
// Signal bundle between a raw input source and debounce_synchronizer.
// glitch_cnt exists only with DEBOUNCE_GLITCH_CNT_EN.
interface debounce_synchronizer_if;
    logic       a;
    logic       out;
    logic       busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    modport master (
        output a,
        input  out,
        input  busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        input  glitch_cnt
`endif
    );

    modport slave (
        input  a,
        output out,
        output busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        output glitch_cnt
`endif
    );
endinterface

// File: rtl/debounce_synchronizer.sv
// 2-flop synchronizer plus debounce FSM producing a clean registered level.
// Optional macro DEBOUNCE_GLITCH_CNT_EN adds a saturating abort counter.
module debounce_synchronizer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input logic clk,
    input logic rst,
    debounce_synchronizer_if.slave bus
);

    // out is state[1], busy is state[0]: both come straight from flops
    typedef enum logic [1:0] {
        LOW      = 2'b00,
        CHK_HIGH = 2'b01,
        HIGH     = 2'b10,
        CHK_LOW  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    generate
        if (STABLE_CYCLES < 2) begin : g_bad_param
            $error("STABLE_CYCLES must be at least 2");
        end
    endgenerate

    logic             s1;
    logic             s2;
    logic             a_s;
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             abort;

    assign a_s = s2;

    // Two-flop synchronizer for the asynchronous raw input
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.a;
            s2 <= s1;
        end
    end

    // State and qualification counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOW;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state logic: a level change must hold STABLE_CYCLES samples
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        abort      = 1'b0;
        unique case (state)
            LOW: begin
                if (a_s) begin
                    next_state = CHK_HIGH;
                    next_cnt   = CNT_W'(1);
                end
            end
            CHK_HIGH: begin
                if (!a_s) begin
                    next_state = LOW;
                    next_cnt   = '0;
                    abort      = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    next_state = HIGH;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!a_s) begin
                    next_state = CHK_LOW;
                    next_cnt   = CNT_W'(1);
                end
            end
            CHK_LOW: begin
                if (a_s) begin
                    next_state = HIGH;
                    next_cnt   = '0;
                    abort      = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    next_state = LOW;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = LOW;
                next_cnt   = '0;
            end
        endcase
    end

    assign bus.out  = state[1];
    assign bus.busy = state[0];

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_q;

    // Saturating count of aborted qualifications
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_q <= 8'd0;
        end else if (abort && glitch_q != 8'hFF) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign bus.glitch_cnt = glitch_q;
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_debounce_synchronizer.sv
// Directed self-checking bench for debounce_synchronizer (STABLE_CYCLES=4).
// Glitch counter checks are compiled in with DEBOUNCE_GLITCH_CNT_EN.
module tb_debounce_synchronizer;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    debounce_synchronizer_if bus ();

    debounce_synchronizer #(.STABLE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else
            passed++;
    endtask

    task automatic apply_reset;
        rst   = 1'b1;
        bus.a = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        bus.a = 1'b1;
        tick(2);
        chk("reset_out", {7'd0, bus.out}, 8'd0);
        chk("reset_busy", {7'd0, bus.busy}, 8'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("reset_glitch", bus.glitch_cnt, 8'd0);
`endif
        rst = 1'b0;
        tick(5);
        chk("reset_rise_early", {7'd0, bus.out}, 8'd0);
        tick(1);
        chk("reset_rise_on_time", {7'd0, bus.out}, 8'd1);
    endtask

    task automatic test_clean_fall;
        bus.a = 1'b0;
        tick(3);
        chk("fall_busy", {7'd0, bus.busy}, 8'd1);
        chk("fall_out_hold", {7'd0, bus.out}, 8'd1);
        tick(2);
        chk("fall_early", {7'd0, bus.out}, 8'd1);
        tick(1);
        chk("fall_on_time", {7'd0, bus.out}, 8'd0);
        chk("fall_busy_done", {7'd0, bus.busy}, 8'd0);
        tick(4);
    endtask

    task automatic test_clean_rise;
        bus.a = 1'b1;
        tick(2);
        chk("rise_idle", {7'd0, bus.busy}, 8'd0);
        tick(1);
        chk("rise_busy_start", {7'd0, bus.busy}, 8'd1);
        tick(2);
        chk("rise_busy_mid", {7'd0, bus.busy}, 8'd1);
        chk("rise_early", {7'd0, bus.out}, 8'd0);
        tick(1);
        chk("rise_on_time", {7'd0, bus.out}, 8'd1);
        chk("rise_busy_done", {7'd0, bus.busy}, 8'd0);
        tick(14);
        chk("rise_hold", {7'd0, bus.out}, 8'd1);
    endtask

    task automatic test_bounce;
        logic [4:0] pat;
        int         rose;
        pat  = 5'b10110;
        rose = 0;
        apply_reset();
        for (int i = 4; i >= 0; i--) begin
            bus.a = pat[i];
            tick(1);
            if (bus.out) rose = 1;
        end
        bus.a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (bus.out) rose = 1;
        end
        chk("bounce_no_rise", rose[7:0], 8'd0);
        tick(1);
        chk("bounce_rise", {7'd0, bus.out}, 8'd1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("bounce_glitch", bus.glitch_cnt, 8'd2);
`endif
    endtask

    task automatic test_short_pulse;
        int rose;
        rose = 0;
        apply_reset();
        bus.a = 1'b1;
        tick(3);
        chk("short_busy", {7'd0, bus.busy}, 8'd1);
        bus.a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out) rose = 1;
            tick(1);
        end
        chk("short_no_rise", rose[7:0], 8'd0);
        chk("short_busy_done", {7'd0, bus.busy}, 8'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("short_glitch", bus.glitch_cnt, 8'd1);
`endif
    endtask

    task automatic test_reset_mid;
        bus.a = 1'b1;
        tick(8);
        chk("mid_high", {7'd0, bus.out}, 8'd1);
        bus.a = 1'b0;
        tick(3);
        chk("mid_chk_low_busy", {7'd0, bus.busy}, 8'd1);
        chk("mid_chk_low_out", {7'd0, bus.out}, 8'd1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_out", {7'd0, bus.out}, 8'd0);
        chk("mid_rst_busy", {7'd0, bus.busy}, 8'd0);
        rst = 1'b0;
        tick(4);
    endtask

`ifdef DEBOUNCE_GLITCH_CNT_EN
    task automatic test_saturation;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            bus.a = 1'b1;
            tick(1);
            bus.a = 1'b0;
            tick(1);
        end
        tick(4);
        chk("sat_255", bus.glitch_cnt, 8'd255);
        for (int i = 0; i < 10; i++) begin
            bus.a = 1'b1;
            tick(1);
            bus.a = 1'b0;
            tick(1);
        end
        tick(4);
        chk("sat_hold", bus.glitch_cnt, 8'd255);
        rst = 1'b1;
        tick(1);
        chk("sat_rst", bus.glitch_cnt, 8'd0);
        rst = 1'b0;
    endtask
`endif

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        bus.a  = 1'b0;
        test_reset();
        test_clean_fall();
        test_clean_rise();
        test_bounce();
        test_short_pulse();
        test_reset_mid();
`ifdef DEBOUNCE_GLITCH_CNT_EN
        test_saturation();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
